// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, capture FSM state type and the
// CRC-16-CCITT byte step used by the optional frame checksum.
package vga_timing_pkg;

  localparam int H_TOTAL  = 32'd800;
  localparam int V_TOTAL  = 32'd525;
  localparam int H_ACTIVE = 32'd640;
  localparam int V_ACTIVE = 32'd480;
  localparam int H_FRONT  = 32'd16;
  localparam int H_SYNC   = 32'd96;
  localparam int V_FRONT  = 32'd10;
  localparam int V_SYNC   = 32'd2;
  localparam int H_BACK   = 32'd48;
  localparam int V_BACK   = 32'd33;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vga_state_e;

  // Polynomial 0x1021, data MSB first, whole byte folded into the top of the register.
  function automatic logic [15:0] crc16_ccitt_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_crc16.sv
// One-byte-per-clock CRC-16-CCITT step; used only when VGA_CAPTURE_CRC_EN is defined.
module vga_crc16
  import vga_timing_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  assign crc_out = crc16_ccitt_step(crc_in, data);

endmodule

// File: rtl/vga_capture.sv
// VGA capture: measures sync timing, locks on a stable mode and outputs active pixels.
// Define VGA_CAPTURE_CRC_EN to add the per-frame frame_crc output.
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int   HACTIVE       = H_ACTIVE,
  parameter int   VACTIVE       = V_ACTIVE,
  parameter int   HSYNCPULSE    = H_SYNC,
  parameter int   HBACKPORCH    = H_BACK,
  parameter int   VSYNCPULSE    = V_SYNC,
  parameter int   VBACKPORCH    = V_BACK,
  parameter logic HSYNCPOLARITY = 1'b0,
  parameter logic VSYNCPOLARITY = 1'b0,
  parameter int   LOCK_FRAMES   = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [2:0]  rin,
  input  logic [2:0]  gin,
  input  logic [1:0]  bin,
  output logic [2:0]  rout,
  output logic [2:0]  gout,
  output logic [1:0]  bout,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
`ifdef VGA_CAPTURE_CRC_EN
  output logic [15:0] frame_crc,
`endif
  output logic        err
);

  localparam logic [10:0] H_START   = 11'(HSYNCPULSE + HBACKPORCH);
  localparam logic [10:0] H_STOP    = 11'(HSYNCPULSE + HBACKPORCH + HACTIVE);
  localparam logic [10:0] V_START   = 11'(VSYNCPULSE + VBACKPORCH);
  localparam logic [10:0] V_STOP    = 11'(VSYNCPULSE + VBACKPORCH + VACTIVE);
  localparam logic [9:0]  H_START10 = 10'(HSYNCPULSE + HBACKPORCH);
  localparam logic [9:0]  V_START10 = 10'(VSYNCPULSE + VBACKPORCH);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;
  // LOCK_FRAMES identical frames means LOCK_FRAMES-1 matches between neighbours.
  localparam logic [7:0]  LOCK_TGT  = (LOCK_FRAMES > 1) ? 8'(LOCK_FRAMES - 1) : 8'd0;

  vga_state_e state_q, state_d;
  logic       hs_prev_q, vs_prev_q, hs_edge_s, vs_edge_s;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hcnt_inc_s, vcnt_inc_s, fl_new_s;
  logic       vs_pend_q, vs_pend_d;
  logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d, prev_ll_q, prev_ll_d;
  logic [7:0] match_q, match_d, match_inc_s;
  logic       sat_s, h_act_s, v_act_s;
  logic [2:0] rout_q, rout_d, gout_q, gout_d;
  logic [1:0] bout_q, bout_d;
  logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic       pix_valid_q, pix_valid_d, frame_start_q, locked_q, locked_d, err_q, err_d;

  // Sync edges and raster counters for the sample presented this cycle.
  always_comb begin
    hs_edge_s  = (hs_prev_q != HSYNCPOLARITY) && (hs == HSYNCPOLARITY);
    vs_edge_s  = (vs_prev_q != VSYNCPOLARITY) && (vs == VSYNCPOLARITY);
    hcnt_inc_s = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
    vcnt_inc_s = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 10'd1;
    hcnt_d     = hs_edge_s ? 10'd0 : hcnt_inc_s;
    if (hs_edge_s) begin
      vcnt_d = vs_pend_q ? 10'd0 : vcnt_inc_s;
    end else begin
      vcnt_d = vcnt_q;
    end
    // hs is handled before vs, so a coincident vs edge clears vcnt on the next line.
    vs_pend_d     = vs_edge_s | (vs_pend_q & ~hs_edge_s);
    fl_new_s      = (vcnt_d == CNT_MAX) ? CNT_MAX : vcnt_d + 10'd1;
    line_len_d    = hs_edge_s ? hcnt_inc_s : line_len_q;
    frame_lines_d = vs_edge_s ? fl_new_s : frame_lines_q;
    prev_ll_d     = vs_edge_s ? line_len_d : prev_ll_q;
    sat_s         = (hcnt_d == CNT_MAX);
  end

  // Lock state machine next-state and error pulse.
  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    err_d       = 1'b0;
    match_inc_s = (match_q == 8'hFF) ? match_q : match_q + 8'd1;
    if (sat_s) begin
      state_d = ST_SEARCH;
      match_d = 8'd0;
      err_d   = (state_q == ST_LOCKED);
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (vs_edge_s) begin
            state_d = ST_MEASURE;
            match_d = 8'd0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_MEASURE: begin
          if (vs_edge_s) begin
            if ((line_len_d == prev_ll_q) && (fl_new_s == frame_lines_q)) begin
              match_d = match_inc_s;
              state_d = (match_inc_s >= LOCK_TGT) ? ST_LOCKED : ST_MEASURE;
            end else begin
              match_d = 8'd0;
            end
          end else begin
            state_d = ST_MEASURE;
          end
        end
        ST_LOCKED: begin
          if ((hs_edge_s && (hcnt_inc_s != line_len_q)) ||
              (vs_edge_s && (fl_new_s != frame_lines_q))) begin
            state_d = ST_SEARCH;
            match_d = 8'd0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          match_d = 8'd0;
        end
      endcase
    end
  end

  // Pixel qualification and output values for the current sample.
  always_comb begin
    h_act_s     = ({1'b0, hcnt_d} >= H_START) && ({1'b0, hcnt_d} < H_STOP);
    v_act_s     = ({1'b0, vcnt_d} >= V_START) && ({1'b0, vcnt_d} < V_STOP);
    locked_d    = (state_d == ST_LOCKED);
    pix_valid_d = locked_d && h_act_s && v_act_s;
    if (h_act_s && v_act_s) begin
      xpos_d = hcnt_d - H_START10;
      ypos_d = vcnt_d - V_START10;
    end else begin
      xpos_d = 10'd0;
      ypos_d = 10'd0;
    end
    if (pix_valid_d) begin
      rout_d = rin;
      gout_d = gin;
      bout_d = bin;
    end else begin
      rout_d = 3'd0;
      gout_d = 3'd0;
      bout_d = 2'd0;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      hs_prev_q     <= ~HSYNCPOLARITY;
      vs_prev_q     <= ~VSYNCPOLARITY;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      vs_pend_q     <= 1'b0;
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
      prev_ll_q     <= 10'd0;
      match_q       <= 8'd0;
      rout_q        <= 3'd0;
      gout_q        <= 3'd0;
      bout_q        <= 2'd0;
      xpos_q        <= 10'd0;
      ypos_q        <= 10'd0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs;
      vs_prev_q     <= vs;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vs_pend_q     <= vs_pend_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      prev_ll_q     <= prev_ll_d;
      match_q       <= match_d;
      rout_q        <= rout_d;
      gout_q        <= gout_d;
      bout_q        <= bout_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= vs_edge_s;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign rout        = rout_q;
  assign gout        = gout_q;
  assign bout        = bout_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign err         = err_q;

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_acc_q, crc_acc_d, crc_next_s, frame_crc_q, frame_crc_d;

  vga_crc16 u_crc16 (
    .crc_in  (crc_acc_q),
    .data    ({rin, gin, bin}),
    .crc_out (crc_next_s)
  );

  // Running checksum restarts at each frame edge; the finished value is published there.
  always_comb begin
    if (vs_edge_s) begin
      crc_acc_d   = 16'hFFFF;
      frame_crc_d = crc_acc_q;
    end else begin
      crc_acc_d   = pix_valid_d ? crc_next_s : crc_acc_q;
      frame_crc_d = frame_crc_q;
    end
  end

  // Checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with 800-clock lines and a shortened 8-line frame.
module tb_vga_capture;

  logic        clk = 1'b0;
  logic        rst, hs, vs;
  logic [2:0]  rin, gin, rout, gout;
  logic [1:0]  bin, bout;
  logic [9:0]  xpos, ypos, line_len, frame_lines;
  logic        pix_valid, frame_start, locked, err;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  int checks = 0;
  int errors = 0;
  int sx = 0;
  int sy = 0;
  int line_end = 799;

  always #20 clk = ~clk;

  vga_capture #(
    .HACTIVE(640), .VACTIVE(3), .HSYNCPULSE(96), .HBACKPORCH(48),
    .VSYNCPULSE(2), .VBACKPORCH(2), .HSYNCPOLARITY(1'b0), .VSYNCPOLARITY(1'b0),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .rin(rin), .gin(gin), .bin(bin),
    .rout(rout), .gout(gout), .bout(bout), .xpos(xpos), .ypos(ypos),
    .pix_valid(pix_valid), .frame_start(frame_start), .line_len(line_len),
    .frame_lines(frame_lines), .locked(locked),
`ifdef VGA_CAPTURE_CRC_EN
    .frame_crc(frame_crc),
`endif
    .err(err)
  );

  // One DUT clock with the given inputs; returns #1 after the sampling edge.
  task automatic clk_in(input logic h, input logic v, input logic [7:0] d);
    hs = h;
    vs = v;
    {rin, gin, bin} = d;
    @(posedge clk);
    #1;
  endtask

  // Present raster position (sx,sy): hs low for clocks 0..95, vs low for lines 0..1.
  task automatic step(input logic [7:0] d);
    clk_in((sx < 96) ? 1'b0 : 1'b1, (sy < 2) ? 1'b0 : 1'b1, d);
    if (sx >= line_end) begin
      sx = 0;
      line_end = 799;
      sy = (sy == 7) ? 0 : sy + 1;
    end else begin
      sx++;
    end
  endtask

  task automatic goto(input int x, input int y);
    while (!(sx == x && sy == y)) step(8'h00);
  endtask

  task automatic test_reset;
    rst = 1'b1; hs = 1'b1; vs = 1'b1; {rin, gin, bin} = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pix_valid, locked, err, frame_start} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {pix_valid, locked, err, frame_start});
    end
    checks++;
    if ({rout, gout, bout, xpos, ypos, line_len, frame_lines} !== 48'd0) begin
      errors++; $display("FAIL reset_values: got %h expected 0", {rout, gout, bout, xpos, ypos, line_len, frame_lines});
    end
    rst = 1'b0;
    repeat (3) clk_in(1'b1, 1'b1, 8'h00);
  endtask

  task automatic test_lock;
    step(8'h00);
    checks++;
    if ({frame_start, locked} !== 2'b10) begin
      errors++; $display("FAIL lock_edge1: got fs/locked %b expected 10", {frame_start, locked});
    end
    goto(0, 0);
    step(8'h00);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL lock_edge2: got locked %b expected 0", locked);
    end
    goto(0, 0);
    step(8'h00);
    checks++;
    if ({frame_start, locked, err} !== 3'b110) begin
      errors++; $display("FAIL lock_edge3: got fs/locked/err %b expected 110", {frame_start, locked, err});
    end
    checks++;
    if (line_len !== 10'd800 || frame_lines !== 10'd8) begin
      errors++; $display("FAIL lock_measure: got line_len %0d frame_lines %0d expected 800 8", line_len, frame_lines);
    end
    step(8'h00);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL frame_start_pulse: got %b expected 0", frame_start);
    end
  endtask

  task automatic test_pixels;
    goto(200, 4);
    step(8'hFF);
    checks++;
    if ({pix_valid, rout, gout, bout, xpos, ypos} !== 29'd0) begin
      errors++; $display("FAIL pix_above_active: got %h expected 0", {pix_valid, rout, gout, bout, xpos, ypos});
    end
    goto(144, 5);
    step(8'hA5);
    checks++;
    if ({pix_valid, rout, gout, bout, xpos, ypos} !== {1'b1, 8'hA5, 10'd0, 10'd0}) begin
      errors++; $display("FAIL pix_first: got v=%b c=%h x=%0d y=%0d expected v=1 c=a5 x=0 y=0", pix_valid, {rout, gout, bout}, xpos, ypos);
    end
    goto(143, 6);
    step(8'hFF);
    checks++;
    if ({pix_valid, rout, gout, bout} !== 9'd0) begin
      errors++; $display("FAIL pix_left_edge: got v=%b c=%h expected 0", pix_valid, {rout, gout, bout});
    end
    goto(783, 7);
    step(8'h3C);
    checks++;
    if ({pix_valid, rout, gout, bout, xpos, ypos} !== {1'b1, 8'h3C, 10'd639, 10'd2}) begin
      errors++; $display("FAIL pix_last: got v=%b c=%h x=%0d y=%0d expected v=1 c=3c x=639 y=2", pix_valid, {rout, gout, bout}, xpos, ypos);
    end
    step(8'hFF);
    checks++;
    if ({pix_valid, rout, gout, bout, xpos, ypos} !== 29'd0) begin
      errors++; $display("FAIL pix_right_edge: got v=%b c=%h x=%0d y=%0d expected 0", pix_valid, {rout, gout, bout}, xpos, ypos);
    end
  endtask

  task automatic test_short_line;
    goto(0, 3);
    line_end = 798;
    goto(0, 4);
    checks++;
    if ({locked, err} !== 2'b10) begin
      errors++; $display("FAIL short_before: got locked/err %b expected 10", {locked, err});
    end
    step(8'h00);
    checks++;
    if ({locked, err} !== 2'b01) begin
      errors++; $display("FAIL short_err: got locked/err %b expected 01", {locked, err});
    end
    step(8'h00);
    checks++;
    if ({locked, err} !== 2'b00) begin
      errors++; $display("FAIL short_err_pulse: got locked/err %b expected 00", {locked, err});
    end
    goto(0, 0);
    step(8'h00);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL short_measure: got locked %b expected 0", locked);
    end
    goto(0, 0);
    step(8'h00);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL short_relock: got locked %b expected 1", locked);
    end
  endtask

  task automatic test_reset_relock;
    goto(400, 6);
    step(8'h5A);
    checks++;
    if ({pix_valid, rout, gout, bout, xpos, ypos} !== {1'b1, 8'h5A, 10'd256, 10'd1}) begin
      errors++; $display("FAIL rst_pre_pixel: got v=%b c=%h x=%0d y=%0d expected v=1 c=5a x=256 y=1", pix_valid, {rout, gout, bout}, xpos, ypos);
    end
    {rin, gin, bin} = 8'hFF;
    rst = 1'b1;
    #2;
    checks++;
    if ({pix_valid, locked, err, frame_start, rout, gout, bout, xpos, ypos, line_len, frame_lines} !== 52'd0) begin
      errors++; $display("FAIL rst_async: got v=%b l=%b c=%h x=%0d y=%0d ll=%0d fl=%0d expected 0", pix_valid, locked, {rout, gout, bout}, xpos, ypos, line_len, frame_lines);
    end
    repeat (3) step(8'hFF);
    rst = 1'b0;
    goto(0, 0);
    step(8'h00);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL rst_relock_edge1: got locked %b expected 0", locked);
    end
    goto(0, 0);
    step(8'h00);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL rst_relock_edge2: got locked %b expected 0", locked);
    end
    goto(0, 0);
    step(8'h00);
    checks++;
    if (locked !== 1'b1 || frame_lines !== 10'd8) begin
      errors++; $display("FAIL rst_relock_edge3: got locked %b frame_lines %0d expected 1 8", locked, frame_lines);
    end
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_model(input int nbytes, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int n = 0; n < nbytes; n++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic test_crc;
    logic [15:0] exp_crc;
    exp_crc = crc_model(3 * 640, 8'h00);
    for (int f = 0; f < 2; f++) begin
      goto(0, 0);
      step(8'h00);
      checks++;
      if (frame_start !== 1'b1 || frame_crc !== exp_crc) begin
        errors++; $display("FAIL crc_frame%0d: got fs=%b crc=%h expected fs=1 crc=%h", f, frame_start, frame_crc, exp_crc);
      end
    end
  endtask
`endif

  task automatic test_timeout;
    int err_seen, bad;
    logic lk223, lk224, err224;
    err_seen = 0; bad = 0; lk223 = 1'b0; lk224 = 1'b1; err224 = 1'b0;
    goto(0, 5);
    for (int k = 1; k <= 1100; k++) begin
      clk_in(1'b1, 1'b1, 8'hFF);
      if (err) err_seen++;
      if (k == 223) lk223 = locked;
      if (k == 224) begin
        lk224 = locked;
        err224 = err;
      end
      if (pix_valid || {rout, gout, bout} != 8'd0 || xpos != 10'd0 || ypos != 10'd0) bad++;
    end
    checks++;
    if ({lk223, lk224, err224} !== 3'b101) begin
      errors++; $display("FAIL timeout_edge: got lk223/lk224/err224 %b expected 101", {lk223, lk224, err224});
    end
    checks++;
    if (err_seen !== 1) begin
      errors++; $display("FAIL timeout_err_count: got %0d expected 1", err_seen);
    end
    checks++;
    if (bad !== 0 || locked !== 1'b0) begin
      errors++; $display("FAIL timeout_outputs: got %0d nonzero pixel cycles locked %b expected 0 0", bad, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_short_line();
    test_reset_relock();
`ifdef VGA_CAPTURE_CRC_EN
    test_crc();
`endif
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter HACTIVE, default 640, active pixels per line.
REQ-002 Parameter VACTIVE, default 480, active lines per frame.
REQ-003 Parameter HSYNCPULSE / HBACKPORCH, defaults 96 / 48, horizontal sync width and back porch in clocks.
REQ-004 Parameter VSYNCPULSE / VBACKPORCH, defaults 2 / 33, vertical sync width and back porch in lines.
REQ-005 Parameter HSYNCPOLARITY / VSYNCPOLARITY, defaults 0 / 0, asserted sync level.
REQ-006 Parameter LOCK_FRAMES, default 2, consecutive matching frames required for lock.
REQ-007 clk  input  1  pixel clock (25 MHz); the block has one clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 hs, vs  input  1 each  incoming syncs, synchronous to clk.
REQ-010 rin, gin  input  3 each; bin  input  2  incoming pixel colour.
REQ-011 rout, gout  output  3 each; bout  output  2  captured pixel, zero outside active area.
REQ-012 xpos, ypos  output  10 each  coordinates of captured pixel.
REQ-013 pix_valid  output  1  high when rout/gout/bout/xpos/ypos are a locked active pixel.
REQ-014 frame_start  output  1  one-cycle pulse on each vs assertion edge.
REQ-015 line_len, frame_lines  output  10 each  last measured clocks per line and lines per frame.
REQ-016 locked  output  1; err  output  1  one-cycle pulse on loss of lock.

Function
REQ-017 Sync assertion edge = previous sample deasserted and current sample equals the POLARITY parameter.
REQ-018 hcnt clears to 0 on hs assertion edge, else increments, saturating at 1023.
REQ-019 vcnt clears to 0 on the first hs assertion edge after a vs assertion edge, else increments on each hs assertion edge, saturating at 1023.
REQ-020 Active area: hcnt in [HSYNCPULSE+HBACKPORCH, +HACTIVE) and vcnt in [VSYNCPULSE+VBACKPORCH, +VACTIVE), half-open.
REQ-021 xpos = hcnt-(HSYNCPULSE+HBACKPORCH), ypos = vcnt-(VSYNCPULSE+VBACKPORCH), both 0 outside active area.
REQ-022 Outputs registered; latency 1 clk from rin/gin/bin/hs sample to rout/gout/bout/xpos/ypos/pix_valid, all mutually aligned.
REQ-023 FSM states SEARCH, MEASURE, LOCKED; reset enters SEARCH.
REQ-024 SEARCH -> MEASURE on vs assertion edge; match counter cleared.
REQ-025 MEASURE: at each vs assertion edge, if line_len and frame_lines equal the previous frame's, match counter increments, else it clears; reaching LOCK_FRAMES -> LOCKED.
REQ-026 LOCKED: an hs period differing from line_len, or frame_lines change at vs edge -> err pulse, SEARCH.
REQ-027 Any state: hcnt saturating (no hs for 1023 clocks) -> SEARCH; err pulses only if leaving LOCKED.
REQ-028 pix_valid = locked AND active area; rout/gout/bout forced 0 whenever pix_valid is 0.
REQ-029 line_len updates at each hs edge with hcnt+1; frame_lines updates at each vs edge with vcnt+1.
REQ-030 Simultaneous hs and vs assertion edges: hs processed first, then vcnt cleared per REQ-019 on the next hs edge.

Reset
REQ-031 rst asynchronously forces: state SEARCH, hcnt/vcnt/line_len/frame_lines 0, all outputs 0, sync history registers to deasserted level.
REQ-032 rst mid-frame: lock reacquired only after LOCK_FRAMES+1 full vs edges post-release.

Configuration
REQ-033 Macro VGA_CAPTURE_CRC_EN: when defined, adds output frame_crc (16 bits), CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {rin,gin,bin} of every pix_valid pixel, latched and presented on the frame_start cycle; when undefined, port and logic absent, no other behaviour change.

Structure
REQ-034 Package vga_timing_pkg holds the 640x480@60 timing constants (800, 525, 640, 480, 16, 96, 10, 2, 48, 33) and the FSM state typedef.
REQ-035 Sub-module vga_crc16 (one-byte-per-clock CRC step) instantiated only under VGA_CAPTURE_CRC_EN.

Verification
REQ-036 Standard 800x525 timing, polarity 0, 3 frames -> locked rises at 3rd vs edge, line_len=800, frame_lines=525.
REQ-037 Locked, pixel at hcnt 144, vcnt 35 = 0xA5 -> one clk later xpos=0, ypos=0, pix_valid=1, {rout,gout,bout}=0xA5; hcnt 784 -> pix_valid=0, colour 0.
REQ-038 Locked, one line shortened to 799 clocks -> err pulse 1 clk, locked=0, state SEARCH.
REQ-039 hs held deasserted for 1100 clocks -> SEARCH by clock 1023, all pixel outputs 0.
REQ-040 rst asserted mid-line during LOCKED -> outputs 0 immediately (no clock edge), relock after 3 frames.
REQ-041 With VGA_CAPTURE_CRC_EN, constant 0x00 frame -> frame_crc identical across frames and matches model on frame_start.
